// File: rtl/rvm_shift_iter.sv
// rvm_shift_iter: multi-cycle iterative shifter/rotator, up to STEP bits per cycle
//
// Ports
//   clk        clock, rising edge
//   resetn     synchronous active-low reset
//   flush      abort current operation, return to IDLE
//   req_valid  request present
//   req_ready  request can be accepted (IDLE only)
//   req_op     000 NOP, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR, 11x NOP
//   req_lhs    value to shift
//   req_rhs    shift amount
//   rsp_valid  result available (held until rsp_ready)
//   rsp_ready  consumer accepts the result
//   rsp_result shifted value
module rvm_shift_iter #(
    parameter int XLEN = 32,
    parameter int STEP = 1,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_lhs,
    input  logic [SHW-1:0]  req_rhs,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);
    localparam logic [SHW:0] XW     = (SHW+1)'(XLEN);

    state_t                state, state_nx;
    logic [2:0]            op_q, op_nx;
    logic [XLEN-1:0]       val_q, val_nx, shifted;
    logic [SHW-1:0]        rem_q, rem_nx, n;
    logic [SHW:0]          back;
    logic signed [XLEN-1:0] sra_v;

    assign req_ready  = state == IDLE;
    assign rsp_valid  = state == DONE;
    assign rsp_result = val_q;

    // n never exceeds rem_q < XLEN, so it always fits in SHW bits even when STEP == XLEN
    assign n     = ({1'b0, rem_q} < STEP_W) ? rem_q : STEP_W[SHW-1:0];
    assign back  = XW - {1'b0, n};
    // arithmetic shift of the working value keeps the captured sign bit in place
    assign sra_v = $signed(val_q) >>> n;

    always_comb begin
        shifted = op_q == 3'd1 ? val_q << n :
                  op_q == 3'd2 ? val_q >> n :
                  op_q == 3'd3 ? sra_v :
                  op_q == 3'd4 ? (val_q << n) | (val_q >> back) :
                                 (val_q >> n) | (val_q << back);
    end

    always_comb begin
        state_nx = state;
        op_nx    = op_q;
        val_nx   = val_q;
        rem_nx   = rem_q;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op_nx    = req_op;
                    val_nx   = req_lhs;
                    rem_nx   = req_rhs;
                    state_nx = (req_rhs != '0 && req_op != 3'd0 && req_op < 3'd6) ? SHIFT : DONE;
                end
                SHIFT: begin
                    val_nx   = shifted;
                    rem_nx   = rem_q - n;
                    state_nx = (rem_q == n) ? DONE : SHIFT;
                end
                DONE: if (rsp_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            op_q  <= '0;
            val_q <= '0;
            rem_q <= '0;
        end else begin
            state <= state_nx;
            op_q  <= op_nx;
            val_q <= val_nx;
            rem_q <= rem_nx;
        end
    end
endmodule

// File: tb/tb_rvm_shift_iter.sv
// tb_rvm_shift_iter: directed and random checks of rvm_shift_iter at STEP = 1, 2, 4, 32
module tb_rvm_shift_iter;
    localparam int NI = 4;

    logic        clk = 0, resetn = 0, flush = 0, req_valid = 0, rsp_ready = 0;
    logic [2:0]  req_op = 0;
    logic [31:0] req_lhs = 0;
    logic [4:0]  req_rhs = 0;
    logic        rdy [NI];
    logic        vld [NI];
    logic [31:0] res [NI];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    function automatic int step_of(int i);
        return i == 3 ? 32 : (1 << i);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        rvm_shift_iter #(.XLEN(32), .STEP(g == 3 ? 32 : (1 << g))) u_dut (
            .clk(clk), .resetn(resetn), .flush(flush),
            .req_valid(req_valid), .req_ready(rdy[g]), .req_op(req_op),
            .req_lhs(req_lhs), .req_rhs(req_rhs),
            .rsp_valid(vld[g]), .rsp_ready(rsp_ready), .rsp_result(res[g])
        );
    end

    function automatic logic [31:0] model(logic [2:0] op, logic [31:0] a, int s);
        logic [31:0] r;
        r = a;
        case (op)
            3'd1: r = a << s;
            3'd2: r = a >> s;
            3'd3: r = $signed(a) >>> s;
            3'd4: for (int i = 0; i < 32; i++) r[(i + s) % 32] = a[i];
            3'd5: for (int i = 0; i < 32; i++) r[i] = a[(i + s) % 32];
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic int lat_of(logic [2:0] op, int s, int st);
        return (op == 0 || op > 5 || s == 0) ? 1 : 1 + (s + st - 1) / st;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] lhs, input logic [4:0] rhs, input int hold);
        int lat [NI];
        logic [31:0] exp;
        bit all;
        @(negedge clk);
        for (int i = 0; i < NI; i++) chk($sformatf("ready_before[%0d]", i), 32'(rdy[i]), 1);
        req_valid = 1; req_op = op; req_lhs = lhs; req_rhs = rhs;
        @(negedge clk);
        req_valid = 0; req_op = 3'($urandom); req_lhs = $urandom; req_rhs = 5'($urandom);
        for (int i = 0; i < NI; i++) lat[i] = -1;
        for (int c = 1; c <= 60; c++) begin
            all = 1;
            for (int i = 0; i < NI; i++) begin
                if (vld[i] && lat[i] < 0) lat[i] = c;
                if (lat[i] < 0) all = 0;
            end
            if (all) break;
            @(negedge clk);
        end
        exp = model(op, lhs, int'(rhs));
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("result[%0d] op=%0d rhs=%0d", i, op, rhs), res[i], exp);
            chk($sformatf("latency[%0d] op=%0d rhs=%0d", i, op, rhs), lat[i], lat_of(op, int'(rhs), step_of(i)));
            chk($sformatf("ready_busy[%0d]", i), 32'(rdy[i]), 0);
        end
        repeat (hold) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("hold_valid[%0d]", i), 32'(vld[i]), 1);
                chk($sformatf("hold_result[%0d]", i), res[i], exp);
                chk($sformatf("hold_ready[%0d]", i), 32'(rdy[i]), 0);
            end
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("ready_after[%0d]", i), 32'(rdy[i]), 1);
            chk($sformatf("valid_after[%0d]", i), 32'(vld[i]), 0);
        end
    endtask

    task automatic abort_mid(input bit use_reset);
        @(negedge clk);
        req_valid = 1; req_op = 3'd1; req_lhs = $urandom; req_rhs = 5'd20;
        @(negedge clk);
        req_valid = 0;
        repeat (3) begin
            for (int i = 0; i < 3; i++) chk($sformatf("abort_novalid[%0d]", i), 32'(vld[i]), 0);
            @(negedge clk);
        end
        if (use_reset) resetn = 0; else flush = 1;
        @(negedge clk);
        resetn = 1; flush = 0;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("abort_valid[%0d] rst=%0d", i, use_reset), 32'(vld[i]), 0);
            chk($sformatf("abort_ready[%0d] rst=%0d", i, use_reset), 32'(rdy[i]), 1);
            if (use_reset) chk($sformatf("reset_result[%0d]", i), res[i], 0);
        end
        repeat (25) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) chk($sformatf("abort_quiet[%0d]", i), 32'(vld[i]), 0);
        end
        do_op(3'd1, 32'd3, 5'd1, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_ready[%0d]", i), 32'(rdy[i]), 1);
            chk($sformatf("rst_valid[%0d]", i), 32'(vld[i]), 0);
            chk($sformatf("rst_result[%0d]", i), res[i], 0);
        end
        resetn = 1;
        do_op(3'd1, 32'h0000_0001, 5'd31, 0);
        do_op(3'd3, 32'h8000_00F0, 5'd4, 0);
        do_op(3'd2, 32'h8000_00F0, 5'd4, 0);
        do_op(3'd5, 32'h0000_00A5, 5'd8, 0);
        do_op(3'd4, 32'h0000_00A5, 5'd8, 0);
        do_op(3'd1, 32'hDEAD_BEEF, 5'd0, 0);
        do_op(3'd0, 32'hDEAD_BEEF, 5'd5, 0);
        do_op(3'd6, 32'hDEAD_BEEF, 5'd7, 0);
        do_op(3'd3, 32'hF0F0_1234, 5'd31, 0);
        do_op(3'd5, $urandom, 5'd31, 10);
        @(negedge clk);
        flush = 1; req_valid = 1; req_op = 3'd0;
        @(negedge clk);
        flush = 0; req_valid = 0;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("flush_idle_ready[%0d]", i), 32'(rdy[i]), 1);
            chk($sformatf("flush_idle_valid[%0d]", i), 32'(vld[i]), 0);
        end
        abort_mid(0);
        abort_mid(1);
        repeat (24) do_op(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
